// File: rtl/game_stage_ctrl_if.sv
// Link bundle between the stage sequencer and the inter-board transceivers.
// rx_* : per-peer levels from the remote boards (one bit per peer)
// tx_* : local levels broadcast to every remote board
// master modport is the sequencer side, slave modport is the transceiver side.
interface game_stage_ctrl_if #(
    parameter int unsigned NPEER = 1
) ();
    logic [NPEER-1:0] rx_connect;
    logic [NPEER-1:0] rx_start;
    logic [NPEER-1:0] rx_finish;
    logic             tx_connect;
    logic             tx_start;
    logic             tx_finish;

    modport master (
        input  rx_connect, rx_start, rx_finish,
        output tx_connect, tx_start, tx_finish
    );

    modport slave (
        output rx_connect, rx_start, rx_finish,
        input  tx_connect, tx_start, tx_finish
    );
endinterface

// File: rtl/game_stage_ctrl.sv
// Stage sequencer for the networked Sudoku game: MENU -> COUNT -> GAME -> OVER,
// with per-peer link supervision, synchronised start countdown and winner id.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   mouse_left_i          : raw left button level (1 = pressed)
//   on_start_i/on_connect_i/on_return_i : cursor over the matching button
//   local_finish_i        : local puzzle solved
//   link                  : rx/tx connect/start/finish bundle (master side)
//   role_o                : 0 = master, 1 = slave
//   linked_o              : per-peer link established
//   state_o               : MENU=0, COUNT=1, GAME=2, OVER=3
//   game_init_o           : holds the game core in init (decoded from state)
//   win_o, winner_id_o    : result, valid in OVER (0 = local, i+1 = peer i)
module game_stage_ctrl #(
    parameter int unsigned NPEER     = 1,
    parameter int unsigned COUNT_CYC = 100_000_000,
    parameter int unsigned LINK_TO   = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mouse_left_i,
    input  logic              on_start_i,
    input  logic              on_connect_i,
    input  logic              on_return_i,
    input  logic              local_finish_i,
    game_stage_ctrl_if.master link,
    output logic              role_o,
    output logic [NPEER-1:0]  linked_o,
    output logic [1:0]        state_o,
    output logic              game_init_o,
    output logic              win_o,
    output logic [2:0]        winner_id_o
);
    localparam int unsigned CNT_W = (COUNT_CYC > 1) ? $clog2(COUNT_CYC) : 1;
    localparam int unsigned LTO_W = $clog2(LINK_TO + 1);

    localparam logic [1:0] S_MENU  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_GAME  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic ROLE_MASTER = 1'b0;
    localparam logic ROLE_SLAVE  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COUNT_CYC - 1);
    localparam logic [LTO_W-1:0] LTO_MAX  = LTO_W'(LINK_TO);

    logic [1:0]       state_q, state_d;
    logic             role_q, role_d;
    logic             txc_q, txc_d;
    logic             txs_q, txs_d;
    logic             txf_q, txf_d;
    logic             win_q, win_d;
    logic [2:0]       wid_q, wid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NPEER-1:0] linked_q, linked_d;
    logic [LTO_W-1:0] lto_q [NPEER];
    logic [LTO_W-1:0] lto_d [NPEER];
    logic             mouse_q;
    logic             click_q;

    logic             start_clk, conn_clk, ret_clk;
    logic             peer_hit;
    logic [2:0]       peer_id;

    assign start_clk = click_q & on_start_i;
    assign conn_clk  = click_q & on_connect_i;
    assign ret_clk   = click_q & on_return_i;

    // Lowest-index linked peer reporting finish.
    always_comb begin
        peer_hit = 1'b0;
        peer_id  = 3'd0;
        for (int i = 0; i < NPEER; i++) begin
            if (!peer_hit && link.rx_finish[i] && linked_q[i]) begin
                peer_hit = 1'b1;
                peer_id  = 3'(i + 1);
            end
        end
    end

    // Stage transitions, role/connect control, result capture.
    always_comb begin
        state_d = state_q;
        role_d  = role_q;
        txc_d   = txc_q;
        txf_d   = txf_q;
        win_d   = win_q;
        wid_d   = wid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_MENU: begin
                if (conn_clk) begin
                    if (txc_q) begin
                        txc_d  = 1'b0;
                        role_d = ROLE_MASTER;
                    end else begin
                        txc_d  = 1'b1;
                        role_d = (|link.rx_connect) ? ROLE_SLAVE : ROLE_MASTER;
                    end
                end
                if (role_q == ROLE_MASTER) begin
                    if (start_clk) state_d = S_COUNT;
                end else if (|(link.rx_start & linked_q)) begin
                    state_d = S_COUNT;
                end
                if (state_d == S_COUNT) cnt_d = CNT_LOAD;
            end
            S_COUNT: begin
                // A slave that lost every master link abandons the countdown.
                if (role_q == ROLE_SLAVE && linked_q == '0) state_d = S_MENU;
                else if (cnt_q == '0)                      state_d = S_GAME;
                else                                       cnt_d = cnt_q - CNT_W'(1);
            end
            S_GAME: begin
                if (local_finish_i) begin
                    state_d = S_OVER;
                    win_d   = 1'b1;
                    wid_d   = 3'd0;
                    txf_d   = 1'b1;
                end else if (peer_hit) begin
                    state_d = S_OVER;
                    win_d   = 1'b0;
                    wid_d   = peer_id;
                end
            end
            S_OVER: begin
                if (ret_clk) begin
                    state_d = S_MENU;
                    win_d   = 1'b0;
                    wid_d   = 3'd0;
                    txf_d   = 1'b0;
                end
            end
            default: state_d = S_MENU;
        endcase
        txs_d = (state_d == S_COUNT) && (role_d == ROLE_MASTER);
    end

    // Per-peer link set/timeout; dropping tx_connect wipes all link state.
    always_comb begin
        linked_d = linked_q;
        lto_d    = lto_q;
        for (int i = 0; i < NPEER; i++) begin
            if (!txc_d) begin
                lto_d[i]    = '0;
                linked_d[i] = 1'b0;
            end else begin
                if (link.rx_connect[i])     lto_d[i] = '0;
                else if (lto_q[i] != LTO_MAX) lto_d[i] = lto_q[i] + LTO_W'(1);
                if (txc_q && link.rx_connect[i]) linked_d[i] = 1'b1;
                else if (lto_d[i] == LTO_MAX)    linked_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_MENU;
            role_q   <= ROLE_MASTER;
            txc_q    <= 1'b0;
            txs_q    <= 1'b0;
            txf_q    <= 1'b0;
            win_q    <= 1'b0;
            wid_q    <= 3'd0;
            cnt_q    <= '0;
            linked_q <= '0;
            lto_q    <= '{default: '0};
            mouse_q  <= 1'b0;
            click_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            role_q   <= role_d;
            txc_q    <= txc_d;
            txs_q    <= txs_d;
            txf_q    <= txf_d;
            win_q    <= win_d;
            wid_q    <= wid_d;
            cnt_q    <= cnt_d;
            linked_q <= linked_d;
            lto_q    <= lto_d;
            mouse_q  <= mouse_left_i;
            click_q  <= mouse_q & ~mouse_left_i;  // release pulse
        end
    end

    assign link.tx_connect = txc_q;
    assign link.tx_start   = txs_q;
    assign link.tx_finish  = txf_q;
    assign role_o          = role_q;
    assign linked_o        = linked_q;
    assign state_o         = state_q;
    assign win_o           = win_q;
    assign winner_id_o     = wid_q;
    assign game_init_o     = (state_q != S_GAME);
endmodule
